// File: rtl/scope_pkg.sv
// rtl/scope_pkg.sv - shared scope constants, sample type and capture reader state encoding
package scope_pkg;
    localparam int DATA_W      = 12;
    localparam int DEPTH       = 512;
    localparam int ADDR_W      = 9;
    localparam int H_ACTIVE    = 800;
    localparam int V_ACTIVE    = 600;
    localparam int X_OFFSET    = 144;
    localparam int Y_ORIGIN    = V_ACTIVE;
    localparam int SCALE_SHIFT = 3;

    typedef logic [DATA_W-1:0] sample_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        EMIT,
        DONE
    } reader_state_t;
endpackage

// File: rtl/trace_scaler.sv
// rtl/trace_scaler.sv - maps an ADC code to a screen y: shift down, invert about Y_ORIGIN, clamp at 0
module trace_scaler #(
    parameter int DATA_W      = scope_pkg::DATA_W,
    parameter int Y_W         = 11,
    parameter int Y_ORIGIN    = scope_pkg::Y_ORIGIN,
    parameter int SCALE_SHIFT = scope_pkg::SCALE_SHIFT
) (
    input  logic [DATA_W-1:0] sample,
    output logic [Y_W-1:0]    y
);
    logic [DATA_W-1:0] shifted;
    logic [Y_W:0]      t;
    logic [Y_W:0]      origin;

    always_comb begin
        shifted = sample >> SCALE_SHIFT;
        t       = (Y_W+1)'(shifted);
        origin  = (Y_W+1)'(Y_ORIGIN);
        // Codes above the origin would land below screen row 0; pin them to the top edge.
        y       = (t > origin) ? '0 : Y_W'(origin - t);
    end
endmodule

// File: rtl/capture_reader.sv
// rtl/capture_reader.sv - reads a capture frame and streams screen points; CAPTURE_READER_MEASURE_EN adds min/max
module capture_reader #(
    parameter int DEPTH       = scope_pkg::DEPTH,
    parameter int ADDR_W      = scope_pkg::ADDR_W,
    parameter int DATA_W      = scope_pkg::DATA_W,
    parameter int X_W         = 11,
    parameter int Y_W         = 11,
    parameter int X_OFFSET    = scope_pkg::X_OFFSET,
    parameter int Y_ORIGIN    = scope_pkg::Y_ORIGIN,
    parameter int SCALE_SHIFT = scope_pkg::SCALE_SHIFT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              capture_done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              pt_valid,
    input  logic              pt_ready,
    output logic [X_W-1:0]    pt_x,
    output logic [Y_W-1:0]    pt_y,
    output logic              pt_last,
    output logic              busy,
    output logic              frame_done,
    output logic              overrun,
`ifdef CAPTURE_READER_MEASURE_EN
    output logic [DATA_W-1:0] meas_min,
    output logic [DATA_W-1:0] meas_max,
    output logic              meas_valid,
`endif
    input  logic              clear_overrun
);
    import scope_pkg::*;

    reader_state_t     state;
    reader_state_t     state_nxt;
    logic [ADDR_W-1:0] index;
    logic [Y_W-1:0]    y_scaled;
    logic              is_last;

    trace_scaler #(
        .DATA_W     (DATA_W),
        .Y_W        (Y_W),
        .Y_ORIGIN   (Y_ORIGIN),
        .SCALE_SHIFT(SCALE_SHIFT)
    ) u_scaler (
        .sample(rd_data),
        .y     (y_scaled)
    );

    assign is_last = (index == ADDR_W'(DEPTH - 1));
    assign rd_addr = index;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (capture_done) state_nxt = FETCH;
            FETCH:   state_nxt = WAIT;
            WAIT:    state_nxt = EMIT;
            EMIT:    if (pt_ready) state_nxt = pt_last ? DONE : FETCH;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd_en      = (state == FETCH);
        pt_valid   = (state == EMIT);
        busy       = (state != IDLE);
        frame_done = (state == DONE);
    end

    // rd_data belongs to the read issued in FETCH, so WAIT is where the point is formed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index   <= '0;
            pt_x    <= '0;
            pt_y    <= '0;
            pt_last <= 1'b0;
        end else begin
            case (state)
                IDLE: if (capture_done) index <= '0;
                WAIT: begin
                    pt_x    <= X_W'(X_OFFSET) + X_W'(index);
                    pt_y    <= y_scaled;
                    pt_last <= is_last;
                end
                EMIT: if (pt_ready && !pt_last) index <= index + ADDR_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (capture_done && state != IDLE) begin
            overrun <= 1'b1;
        end else if (clear_overrun) begin
            overrun <= 1'b0;
        end
    end

`ifdef CAPTURE_READER_MEASURE_EN
    sample_t min_q;
    sample_t max_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_q <= '0;
            max_q <= '0;
        end else if (state == WAIT) begin
            if (index == '0) begin
                min_q <= rd_data;
                max_q <= rd_data;
            end else begin
                if (rd_data < min_q) min_q <= rd_data;
                if (rd_data > max_q) max_q <= rd_data;
            end
        end
    end

    assign meas_min   = min_q;
    assign meas_max   = max_q;
    assign meas_valid = (state == DONE);
`endif
endmodule

// File: tb/tb_capture_reader.sv
// tb/tb_capture_reader.sv - directed bench for capture_reader and trace_scaler
module tb_capture_reader;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        capture_done;
    logic        rd_en;
    logic [8:0]  rd_addr;
    logic [11:0] rd_data;
    logic        pt_valid;
    logic        pt_ready;
    logic [10:0] pt_x;
    logic [10:0] pt_y;
    logic        pt_last;
    logic        busy;
    logic        frame_done;
    logic        overrun;
    logic        clear_overrun;
`ifdef CAPTURE_READER_MEASURE_EN
    logic [11:0] meas_min;
    logic [11:0] meas_max;
    logic        meas_valid;
`endif
    logic [11:0] sc_in;
    logic [10:0] sc_y;

    logic [11:0] mem [0:511];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    capture_reader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .capture_done (capture_done),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .pt_valid     (pt_valid),
        .pt_ready     (pt_ready),
        .pt_x         (pt_x),
        .pt_y         (pt_y),
        .pt_last      (pt_last),
        .busy         (busy),
        .frame_done   (frame_done),
        .overrun      (overrun),
`ifdef CAPTURE_READER_MEASURE_EN
        .meas_min     (meas_min),
        .meas_max     (meas_max),
        .meas_valid   (meas_valid),
`endif
        .clear_overrun(clear_overrun)
    );

    trace_scaler #(.DATA_W(12), .Y_W(11), .Y_ORIGIN(100), .SCALE_SHIFT(3)) u_sc (
        .sample(sc_in),
        .y     (sc_y)
    );

    always_ff @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_y(input int d);
        int t;
        t = d >> 3;
        return (t > 600) ? 0 : 600 - t;
    endfunction

    task automatic zero_check(input string pfx);
        chk({pfx, "_rd_en"}, rd_en, 0);
        chk({pfx, "_rd_addr"}, rd_addr, 0);
        chk({pfx, "_pt_valid"}, pt_valid, 0);
        chk({pfx, "_pt_x"}, pt_x, 0);
        chk({pfx, "_pt_y"}, pt_y, 0);
        chk({pfx, "_pt_last"}, pt_last, 0);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_frame_done"}, frame_done, 0);
        chk({pfx, "_overrun"}, overrun, 0);
    endtask

    // Called at a negedge; launches a frame and follows it to completion (or to a reset at point rst_at).
    task automatic run_frame(input bit stall, input int cd_at, input bit cd_done,
                             input int both_at, input int rst_at);
        int n = 0;
        int cyc = 0;
        int len = 0;
        int fdn = 0;
        bit seen_rd = 0;
        bit hold = 0;
        bit fin = 0;
        logic [10:0] hx, hy;
        logic hl;
        int mn, mx;
        capture_done = 1'b1;
        while (cyc < 6000 && !fin) begin
            @(negedge clk);
            cyc++;
            capture_done  = 1'b0;
            clear_overrun = 1'b0;
            if (rd_en && !seen_rd) begin
                seen_rd = 1;
                chk("first_rd_addr", rd_addr, 0);
            end
            if (seen_rd) len++;
            pt_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (hold) begin
                chk("hold_valid", pt_valid, 1);
                chk("hold_x", pt_x, hx);
                chk("hold_y", pt_y, hy);
                chk("hold_last", pt_last, hl);
            end
            hold = 0;
            if (pt_valid && n == rst_at) begin
                #2 rst_n = 1'b0;
                #1 zero_check("async_rst");
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (pt_valid) begin
                if (pt_ready) begin
                    chk("pt_x", pt_x, 144 + n);
                    chk("pt_y", pt_y, exp_y(int'(mem[n])));
                    chk("pt_last", pt_last, (n == 511) ? 1 : 0);
                    if (mem[n] == 12'd4095) chk("y_code4095", pt_y, 89);
                    if (mem[n] == 12'd0) chk("y_code0", pt_y, 600);
                    if (n == cd_at) capture_done = 1'b1;
                    if (n == both_at) begin
                        capture_done  = 1'b1;
                        clear_overrun = 1'b1;
                    end
                    n++;
                end else begin
                    hold = 1;
                    hx = pt_x;
                    hy = pt_y;
                    hl = pt_last;
                end
            end
            if (frame_done) begin
                fdn++;
                fin = 1;
                chk("points", n, 512);
                if (!stall) chk("frame_len", len, 1537);
`ifdef CAPTURE_READER_MEASURE_EN
                mn = int'(mem[0]);
                mx = int'(mem[0]);
                for (int i = 1; i < 512; i++) begin
                    if (int'(mem[i]) < mn) mn = int'(mem[i]);
                    if (int'(mem[i]) > mx) mx = int'(mem[i]);
                end
                chk("meas_valid", meas_valid, 1);
                chk("meas_min", meas_min, mn);
                chk("meas_max", meas_max, mx);
`else
                mn = 0;
                mx = 0;
`endif
                if (cd_done) capture_done = 1'b1;
            end
        end
        chk("frame_done_once", fdn, 1);
        @(negedge clk);
        capture_done = 1'b0;
        chk("frame_done_drop", frame_done, 0);
        chk("idle_after_frame", busy, 0);
`ifdef CAPTURE_READER_MEASURE_EN
        chk("meas_valid_drop", meas_valid, 0);
`endif
    endtask

    initial begin
        rst_n         = 1'b0;
        capture_done  = 1'b0;
        pt_ready      = 1'b0;
        clear_overrun = 1'b0;
        sc_in         = '0;
        for (int i = 0; i < 512; i++) mem[i] = 12'(i * 8);
        repeat (3) @(negedge clk);
        zero_check("reset");
        rst_n = 1'b1;
        @(negedge clk);

        sc_in = 12'd0;    #1 chk("sc100_code0", sc_y, 100);
        sc_in = 12'd400;  #1 chk("sc100_code400", sc_y, 50);
        sc_in = 12'd808;  #1 chk("sc100_code808", sc_y, 0);
        sc_in = 12'd4095; #1 chk("sc100_code4095", sc_y, 0);
        @(negedge clk);

        run_frame(0, -1, 0, -1, -1);
        chk("overrun_clean", overrun, 0);

        mem[7] = 12'd4095;
        run_frame(1, 100, 1, -1, -1);
        chk("overrun_set", overrun, 1);
        clear_overrun = 1'b1;
        @(negedge clk);
        clear_overrun = 1'b0;
        chk("overrun_cleared", overrun, 0);

        for (int i = 0; i < 512; i++) mem[i] = 12'(100 + i * 7);
        mem[0]   = 12'd2000;
        mem[200] = 12'd37;
        mem[300] = 12'd3980;
        run_frame(0, -1, 0, 50, -1);
        chk("overrun_set_wins", overrun, 1);

        for (int i = 0; i < 512; i++) mem[i] = 12'(i * 8);
        run_frame(1, -1, 0, -1, 250);
        run_frame(0, -1, 0, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/capture_reader.md
Name: capture_reader

Overview:
- Consumer side of the trigger capture buffer.
- On the one-cycle capture-complete pulse from the trigger block, reads all DEPTH stored samples in order through a synchronous read port.
- Converts each sample to a screen point (x = index + X_OFFSET, y = scaled, inverted amplitude).
- Streams points to the VGA trace plotter over a valid/ready handshake and signals frame completion.

Parameters:
- DEPTH, 512, number of samples per capture frame.
- ADDR_W, 9, read address width; must satisfy 2**ADDR_W >= DEPTH.
- DATA_W, 12, sample width (ADC code).
- X_W, 11, screen x coordinate width.
- Y_W, 11, screen y coordinate width.
- X_OFFSET, 144, x of sample 0 on screen.
- Y_ORIGIN, 600, screen y for sample code 0 (bottom of trace area).
- SCALE_SHIFT, 3, right shift applied to sample before inversion.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- capture_done  in  1  one-cycle pulse: capture buffer holds a complete frame.
- rd_en  out  1  read strobe to capture buffer.
- rd_addr  out  ADDR_W  sample index being read.
- rd_data  in  DATA_W  sample; valid exactly one cycle after rd_en.
- pt_valid  out  1  point available.
- pt_ready  in  1  plotter accepts point.
- pt_x  out  X_W  point x.
- pt_y  out  Y_W  point y.
- pt_last  out  1  point is sample DEPTH-1.
- busy  out  1  frame read in progress (state != IDLE).
- frame_done  out  1  one-cycle pulse after last point accepted.
- overrun  out  1  sticky: capture_done arrived while not IDLE.
- clear_overrun  in  1  clears overrun.

Behaviour:
- Reset: async assert forces IDLE from any state, including mid-frame. All outputs go to 0: rd_en, rd_addr, pt_valid, pt_x, pt_y, pt_last, busy, frame_done, overrun. The index counter also resets to 0. Release is synchronous to clk.
- IDLE:
  - capture_done=1 → FETCH, index=0.
  - Otherwise stay.
- FETCH (one cycle):
  - rd_en=1, rd_addr=index.
  - Next state WAIT.
- WAIT (one cycle):
  - Capture rd_data, then register pt_x = X_OFFSET + index and pt_y = scale(rd_data).
  - pt_last = (index == DEPTH-1).
  - pt_valid=1 from the next cycle. Next state EMIT.
- EMIT:
  - pt_valid, pt_x, pt_y and pt_last are held stable until pt_valid && pt_ready.
  - On handshake with pt_last=0: index++, go to FETCH.
  - On handshake with pt_last=1: go to DONE.
  - pt_valid drops in the cycle after the handshake.
- DONE (one cycle): frame_done=1, next state IDLE.
- Latency: capture_done sampled at cycle N gives rd_en at N+1 and pt_valid at N+3. With pt_ready tied high, the steady rate is one point per 3 cycles, so a frame takes 3*DEPTH+1 cycles from N+1.
- scale(d): t = d >> SCALE_SHIFT, zero-extended to Y_W+1 bits.
  - y = Y_ORIGIN - t, clamped to 0 if negative.
  - Defaults: code 0 → 600, code 4095 → 89.
- rd_addr and index are ADDR_W bits wide. index never exceeds DEPTH-1, so there is no wrap within a frame.
- capture_done in any state other than IDLE (including DONE) is ignored for sequencing and sets overrun. The current frame is never restarted.
- If clear_overrun and a new overrun event occur in the same cycle, set wins.
- busy = 1 in FETCH, WAIT, EMIT and DONE.

Optional Feature:
- Macro CAPTURE_READER_MEASURE_EN.
- Defined: adds outputs meas_min (DATA_W), meas_max (DATA_W) and meas_valid (1).
  - Running min and max of raw rd_data over the frame, initialised by sample 0.
  - Final values are presented with a meas_valid pulse coincident with frame_done, then held until the next frame's sample 0.
  - Reset value 0.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package scope_pkg holds:
  - DATA_W, DEPTH, ADDR_W.
  - Screen constants: H_ACTIVE=800, V_ACTIVE=600, trace X_OFFSET/Y_ORIGIN.
  - typedef sample_t (logic [DATA_W-1:0]).
  - reader state enum {IDLE, FETCH, WAIT, EMIT, DONE}.
- One natural sub-module: trace_scaler (combinational shift, invert and clamp), reusable by the cursor and level-marker overlay.

Test Plan:
- Buffer model preloaded with sample[i]=i*8; pulse capture_done; pt_ready=1 → 512 points. Point i has pt_x=144+i and pt_y=600-i; pt_last only on i=511; frame_done exactly once, 1537 cycles after rd_en first rises.
- Random pt_ready stalls (50%) → pt_x/pt_y/pt_last stable while pt_valid && !pt_ready. No point lost or duplicated; order 0..511.
- capture_done pulsed at point 100 and during DONE → frame completes unchanged and overrun=1. clear_overrun alone → 0. clear_overrun coinciding with a new capture_done while busy → stays 1.
- Samples 0, 4095, and a sample where Y_ORIGIN is overridden to 100 → y = 600, 89, and 0 (clamped, where 4095>>3=511 > 100).
- rst_n asserted in EMIT at point 250 → all outputs 0 immediately, asynchronously. Next capture_done restarts from rd_addr=0.
- With CAPTURE_READER_MEASURE_EN: samples ranging 37..3980 → meas_min=37 and meas_max=3980, with meas_valid coincident with frame_done.
